tri_lcb_seq: RTL and testbench
==============================

Name: tri_lcb_seq

Overview:
- Local clock-control sequencer for a group of NBANK aoi22/nlats_wlcb latch banks.
- Produces per-bank act with an idle hold-off, plus the shared thold_b, sg, force_t and d_mode controls.
- Runs the functional → hold → scan-shift → hold → functional handshake on request.
- Sits beside the latch banks in each unit; requesters ask for bank writes or a scan session and never drive LCB controls directly.

Parameters:
NBANK, 4, number of latch banks / act outputs
SCAN_CNT_W, 10, width of scan length counter
THOLD_STAGES, 2, cycles thold_b is held low on each hold entry/exit (min 1)
IDLE_CYC, 3, cycles act stays high after last write request (0 = act follows request only)

Ports:
clk  in  1  single functional clock
rst  in  1  reset, asynchronous, active-high
bank_wr_req  in  NBANK  per-bank write intent
scan_req  in  1  request scan session, sampled in FUNC only
scan_len  in  SCAN_CNT_W  shift cycle count, captured with scan_req
act  out  NBANK  per-bank latch act
thold_b  out  1  1 = functional clocking, 0 = hold
sg  out  1  scan gate
force_t  out  1  force LCB active
d_mode  out  1  pulse-mode disable
scan_busy  out  1  high in every state except FUNC
scan_done  out  1  one-cycle pulse on return to FUNC after a scan session

Behaviour:
- Reset (async) forces these values: state=POR_HOLD, thold_b=0, sg=0, force_t=0, d_mode=0, act=0, scan_busy=1, scan_done=0, all counters 0.
- All outputs except act are registered, Moore decodes of state. act is combinational from state and the idle counters.

State machine:
- POR_HOLD: thold_b=0 for THOLD_STAGES cycles after rst deasserts, then FUNC. scan_done is not pulsed.
- FUNC: thold_b=1, sg=0, force_t=0, scan_busy=0.
  - If scan_req=1, capture scan_len and go to HOLD_ENTER next cycle.
- HOLD_ENTER: thold_b=0 for THOLD_STAGES cycles.
  - Then go to SHIFT, or straight to HOLD_EXIT if the captured length is 0.
- SHIFT: thold_b=1, sg=1, force_t=1, d_mode=1 for exactly scan_len cycles, then HOLD_EXIT.
- HOLD_EXIT: sg=0, force_t=0, d_mode=0, thold_b=0 for THOLD_STAGES cycles, then FUNC.
  - scan_done=1 on the first FUNC cycle only.

Timing and act rules:
- Latency: scan_req at cycle T gives thold_b low over T+1..T+THOLD_STAGES and sg high starting at T+1+THOLD_STAGES.
- Per-bank idle counter: loads IDLE_CYC when bank_wr_req[i]=1, otherwise decrements, saturating at 0.
- In FUNC, act[i] = bank_wr_req[i] | (cnt[i] != 0).
- Outside FUNC, act = 0, counters are cleared, and bank_wr_req is ignored (dropped). Requesters must watch scan_busy.
- scan_req and bank_wr_req in the same FUNC cycle: act is asserted that cycle and the scan is still accepted. act drops the next cycle.
- scan_req outside FUNC is ignored, with no queueing. A scan_req held high re-triggers a new session on the first FUNC cycle after scan_done.
- rst asserted mid-session aborts immediately to reset values. No scan_done is issued.
- scan_len = 2^SCAN_CNT_W - 1 must count fully with no wrap. The counter decrements from the captured value.

Optional Feature:
- Macro TRI_LCB_SEQ_ABORT_EN.
- When defined, two ports are added:
  - scan_abort (input, 1): in SHIFT it forces HOLD_EXIT on the next cycle; ignored in other states.
  - scan_aborted (output, 1): a registered flag valid with scan_done, cleared on the next scan_req accept.
- When not defined, both ports are absent and SHIFT always runs its full count.

Decomposition:
- Shared include/package tri_lcb_seq_pkg: state encoding localparams (POR_HOLD, FUNC, HOLD_ENTER, SHIFT, HOLD_EXIT; 3-bit binary) and the THOLD_STAGES minimum check constant.
- One sub-module, tri_lcb_seq_act_timer: a per-bank idle counter and act decode, instantiated NBANK times by generate.

Test Plan:
- Release rst → thold_b=0 for 2 cycles, then thold_b=1, scan_busy=0, act=0, with no scan_done.
- In FUNC, pulse bank_wr_req[2] for 1 cycle → act[2]=1 for 4 cycles (request + 3 idle), other act bits 0.
- scan_req with scan_len=5 at T → thold_b=0 at T+1..T+2, sg=force_t=d_mode=1 at T+3..T+7, thold_b=0 at T+8..T+9, scan_done=1 at T+10.
- scan_len=0 → no sg cycles, thold_b low for 4 consecutive cycles, scan_done 5 cycles after accept.
- Assert bank_wr_req=4'hF during SHIFT → act stays 0, counters stay 0 on return to FUNC. A second scan_req during HOLD_EXIT is ignored.
- Assert rst in the 3rd SHIFT cycle → sg, force_t and d_mode drop asynchronously, state POR_HOLD, no scan_done. With TRI_LCB_SEQ_ABORT_EN, scan_abort in SHIFT → HOLD_EXIT next cycle, then scan_aborted=1 with scan_done.

Source files
------------

// File: rtl/tri_lcb_seq_pkg.sv
// Shared definitions for the tri_lcb_seq local clock-control sequencer:
// FSM state encoding and the minimum hold-stage count.
package tri_lcb_seq_pkg;

  // 3-bit binary state encoding
  localparam logic [2:0] POR_HOLD   = 3'd0;
  localparam logic [2:0] FUNC       = 3'd1;
  localparam logic [2:0] HOLD_ENTER = 3'd2;
  localparam logic [2:0] SHIFT      = 3'd3;
  localparam logic [2:0] HOLD_EXIT  = 3'd4;

  typedef enum logic [2:0] {
    StPorHold   = POR_HOLD,
    StFunc      = FUNC,
    StHoldEnter = HOLD_ENTER,
    StShift     = SHIFT,
    StHoldExit  = HOLD_EXIT
  } state_e;

  // thold_b must be held low for at least one cycle on every hold entry/exit
  localparam int unsigned THOLD_STAGES_MIN = 1;

  function automatic int unsigned clamp_stages(input int unsigned stages);
    return (stages < THOLD_STAGES_MIN) ? THOLD_STAGES_MIN : stages;
  endfunction

endpackage

// File: rtl/tri_lcb_seq_if.sv
// Requester/sequencer bundle for tri_lcb_seq. The master side (requesters)
// asks for bank writes and scan sessions; the slave side (sequencer) drives
// the LCB controls. Optional macro TRI_LCB_SEQ_ABORT_EN adds scan_abort and
// scan_aborted.
interface tri_lcb_seq_if #(
  parameter int unsigned NBANK      = 4,
  parameter int unsigned SCAN_CNT_W = 10
) ();

  logic [NBANK-1:0]      bank_wr_req;
  logic                  scan_req;
  logic [SCAN_CNT_W-1:0] scan_len;
  logic [NBANK-1:0]      act;
  logic                  thold_b;
  logic                  sg;
  logic                  force_t;
  logic                  d_mode;
  logic                  scan_busy;
  logic                  scan_done;
`ifdef TRI_LCB_SEQ_ABORT_EN
  logic                  scan_abort;
  logic                  scan_aborted;
`endif

  modport master (
    output bank_wr_req,
    output scan_req,
    output scan_len,
`ifdef TRI_LCB_SEQ_ABORT_EN
    output scan_abort,
    input  scan_aborted,
`endif
    input  act,
    input  thold_b,
    input  sg,
    input  force_t,
    input  d_mode,
    input  scan_busy,
    input  scan_done
  );

  modport slave (
    input  bank_wr_req,
    input  scan_req,
    input  scan_len,
`ifdef TRI_LCB_SEQ_ABORT_EN
    input  scan_abort,
    output scan_aborted,
`endif
    output act,
    output thold_b,
    output sg,
    output force_t,
    output d_mode,
    output scan_busy,
    output scan_done
  );

endinterface

// File: rtl/tri_lcb_seq_act_timer.sv
// Per-bank act generator: an idle counter that keeps act high for IDLE_CYC
// cycles after the last write request. Counter is cleared whenever cnt_en
// is low so a bank never carries stale idle time across a scan session.
module tri_lcb_seq_act_timer #(
  parameter int unsigned IDLE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_req,
  input  logic act_en,
  input  logic cnt_en,
  output logic act
);

  localparam int unsigned CntW = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Idle counter next state: reload on request, saturating decrement otherwise
  always_comb begin
    cnt_d = '0;
    if (cnt_en) begin
      if (wr_req) begin
        cnt_d = CntW'(IDLE_CYC);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Idle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // act follows the request immediately and stretches while idle time remains
  always_comb begin
    act = act_en & (wr_req | (cnt_q != '0));
  end

endmodule

// File: rtl/tri_lcb_seq.sv
// Local clock-control sequencer for a group of NBANK latch banks. Runs the
// functional -> hold -> scan-shift -> hold -> functional handshake and
// produces per-bank act plus shared thold_b/sg/force_t/d_mode.
// Optional macro TRI_LCB_SEQ_ABORT_EN enables scan_abort/scan_aborted.
module tri_lcb_seq
  import tri_lcb_seq_pkg::*;
#(
  parameter int unsigned NBANK        = 4,
  parameter int unsigned SCAN_CNT_W   = 10,
  parameter int unsigned THOLD_STAGES = 2,
  parameter int unsigned IDLE_CYC     = 3
) (
  input logic          clk,
  input logic          rst,
  tri_lcb_seq_if.slave bus
);

  localparam int unsigned StgN = clamp_stages(THOLD_STAGES);
  localparam int unsigned StgW = (StgN > 1) ? $clog2(StgN) : 1;

  state_e                state_q, state_d;
  logic [StgW-1:0]       stg_cnt_q, stg_cnt_d;
  logic [SCAN_CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic                  in_hold;
  logic                  stg_done;
  logic                  shift_last;
  logic                  accept;
  logic                  abort_take;

  logic thold_b_q, thold_b_d;
  logic sg_q, sg_d;
  logic force_t_q, force_t_d;
  logic d_mode_q, d_mode_d;
  logic scan_busy_q, scan_busy_d;
  logic scan_done_q, scan_done_d;

  logic [NBANK-1:0] act_w;
  logic             act_en;
  logic             cnt_en;

  assign in_hold    = (state_q == StPorHold) | (state_q == StHoldEnter) |
                      (state_q == StHoldExit);
  assign stg_done   = (stg_cnt_q == StgW'(StgN - 1));
  assign shift_last = (shift_cnt_q == SCAN_CNT_W'(1));
  assign accept     = (state_q == StFunc) & bus.scan_req;

`ifdef TRI_LCB_SEQ_ABORT_EN
  assign abort_take = (state_q == StShift) & bus.scan_abort;
`else
  assign abort_take = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StPorHold;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPorHold: begin
        if (stg_done) state_d = StFunc;
      end
      StFunc: begin
        if (bus.scan_req) state_d = StHoldEnter;
      end
      StHoldEnter: begin
        if (stg_done) state_d = (shift_cnt_q == '0) ? StHoldExit : StShift;
      end
      StShift: begin
        if (shift_last || abort_take) state_d = StHoldExit;
      end
      StHoldExit: begin
        if (stg_done) state_d = StFunc;
      end
      default: state_d = StPorHold;
    endcase
  end

  // Hold-stage and shift-length counters
  always_comb begin
    stg_cnt_d = '0;
    if (in_hold && !stg_done) begin
      stg_cnt_d = stg_cnt_q + StgW'(1);
    end

    shift_cnt_d = shift_cnt_q;
    if (accept) begin
      shift_cnt_d = bus.scan_len;
    end else if (state_q == StShift) begin
      // clear on exit so an aborted session leaves nothing behind
      shift_cnt_d = (state_d == StShift) ? shift_cnt_q - SCAN_CNT_W'(1) : '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_cnt_q   <= '0;
      shift_cnt_q <= '0;
    end else begin
      stg_cnt_q   <= stg_cnt_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Output decode from next state so the registered outputs line up with state
  always_comb begin
    thold_b_d   = (state_d == StFunc) | (state_d == StShift);
    sg_d        = (state_d == StShift);
    force_t_d   = (state_d == StShift);
    d_mode_d    = (state_d == StShift);
    scan_busy_d = (state_d != StFunc);
    scan_done_d = (state_q == StHoldExit) & (state_d == StFunc);
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thold_b_q   <= 1'b0;
      sg_q        <= 1'b0;
      force_t_q   <= 1'b0;
      d_mode_q    <= 1'b0;
      scan_busy_q <= 1'b1;
      scan_done_q <= 1'b0;
    end else begin
      thold_b_q   <= thold_b_d;
      sg_q        <= sg_d;
      force_t_q   <= force_t_d;
      d_mode_q    <= d_mode_d;
      scan_busy_q <= scan_busy_d;
      scan_done_q <= scan_done_d;
    end
  end

`ifdef TRI_LCB_SEQ_ABORT_EN
  logic scan_aborted_q, scan_aborted_d;

  // Abort flag: set when SHIFT is cut short, held until the next session starts
  always_comb begin
    scan_aborted_d = scan_aborted_q;
    if (accept) begin
      scan_aborted_d = 1'b0;
    end else if (abort_take) begin
      scan_aborted_d = 1'b1;
    end
  end

  // Abort flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_aborted_q <= 1'b0;
    end else begin
      scan_aborted_q <= scan_aborted_d;
    end
  end

  assign bus.scan_aborted = scan_aborted_q;
`endif

  // Counters only run while staying in FUNC; a scan accept clears them
  assign act_en = (state_q == StFunc);
  assign cnt_en = act_en & (state_d == StFunc);

  for (genvar i = 0; i < NBANK; i++) begin : g_bank
    tri_lcb_seq_act_timer #(
      .IDLE_CYC(IDLE_CYC)
    ) u_act_timer (
      .clk   (clk),
      .rst   (rst),
      .wr_req(bus.bank_wr_req[i]),
      .act_en(act_en),
      .cnt_en(cnt_en),
      .act   (act_w[i])
    );
  end

  assign bus.act       = act_w;
  assign bus.thold_b   = thold_b_q;
  assign bus.sg        = sg_q;
  assign bus.force_t   = force_t_q;
  assign bus.d_mode    = d_mode_q;
  assign bus.scan_busy = scan_busy_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_tri_lcb_seq.sv
// Self-checking bench for tri_lcb_seq (NBANK=4, SCAN_CNT_W=10,
// THOLD_STAGES=2, IDLE_CYC=3). Expected per-cycle outputs are queued when a
// scenario's stimulus is planned and popped as each cycle is observed.
module tb_tri_lcb_seq;

  localparam int unsigned NBANK      = 4;
  localparam int unsigned SCAN_CNT_W = 10;

  // Observation vector: {thold_b, sg, force_t, d_mode, scan_busy, scan_done, act[3:0]}
  localparam logic [9:0] EXP_FUNC  = 10'h200;
  localparam logic [9:0] EXP_HOLD  = 10'h020;
  localparam logic [9:0] EXP_SHIFT = 10'h3E0;
  localparam logic [9:0] EXP_DONE  = 10'h210;

  logic clk;
  logic rst;

  tri_lcb_seq_if #(.NBANK(NBANK), .SCAN_CNT_W(SCAN_CNT_W)) bus ();

  tri_lcb_seq #(
    .NBANK       (NBANK),
    .SCAN_CNT_W  (SCAN_CNT_W),
    .THOLD_STAGES(2),
    .IDLE_CYC    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [9:0] obs;
  logic [9:0] expv;
  logic [9:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  assign obs = {bus.thold_b, bus.sg, bus.force_t, bus.d_mode, bus.scan_busy, bus.scan_done,
                bus.act};

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef TRI_LCB_SEQ_ABORT_EN
  logic abort_drv = 1'b0;
`endif

  // Drive one cycle's inputs just after the edge, then settle before sampling
  task automatic step(input logic [3:0] wr, input logic sreq, input logic [9:0] len);
    @(posedge clk);
    #1;
    bus.bank_wr_req = wr;
    bus.scan_req    = sreq;
    bus.scan_len    = len;
`ifdef TRI_LCB_SEQ_ABORT_EN
    bus.scan_abort  = abort_drv;
`endif
    #1;
  endtask

  // Expected outputs c cycles after a scan_req accept of length len
  function automatic logic [9:0] scan_exp(input int c, input int len);
    if (c == 0) return EXP_FUNC;
    if (c <= 2) return EXP_HOLD;
    if (c <= 2 + len) return EXP_SHIFT;
    if (c <= 4 + len) return EXP_HOLD;
    if (c == 5 + len) return EXP_DONE;
    return EXP_FUNC;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.bank_wr_req = '0;
    bus.scan_req    = 1'b0;
    bus.scan_len    = '0;
`ifdef TRI_LCB_SEQ_ABORT_EN
    bus.scan_abort  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== EXP_HOLD) $display("FAIL reset_held: got %h want %h", obs, EXP_HOLD);
    else n_pass++;
    rst = 1'b0;
    exp_q.push_back(EXP_HOLD);
    exp_q.push_back(EXP_HOLD);
    exp_q.push_back(EXP_FUNC);
    exp_q.push_back(EXP_FUNC);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) step(4'h0, 1'b0, '0);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL por_release cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_act_idle();
    logic [3:0] a;
    logic [3:0] wr;
    for (int c = 0; c < 13; c++) begin
      a = 4'h0;
      if (c <= 3) a[2] = 1'b1;
      if (c >= 6 && c <= 11) a[0] = 1'b1;
      exp_q.push_back(EXP_FUNC | {6'b0, a});
    end
    for (int c = 0; c < 13; c++) begin
      wr = 4'h0;
      if (c == 0) wr = 4'b0100;
      if (c == 6 || c == 8) wr = 4'b0001;
      step(wr, 1'b0, '0);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL act_idle cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_scan_len(input int len, input string tag);
    int n;
    n = len + 7;
    for (int c = 0; c < n; c++) exp_q.push_back(scan_exp(c, len));
    for (int c = 0; c < n; c++) begin
      step(4'h0, c == 0, 10'(len));
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL %s cyc %0d: got %h want %h", tag, c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_wr_during_scan();
    logic [3:0] wr;
    for (int c = 0; c < 13; c++) begin
      if (c == 0) exp_q.push_back(EXP_FUNC | 10'h00F);
      else exp_q.push_back(scan_exp(c, 5));
    end
    for (int c = 0; c < 13; c++) begin
      wr = (c <= 9) ? 4'hF : 4'h0;
      // second scan_req during HOLD_EXIT must be dropped
      step(wr, (c == 0) || (c == 8), 10'd5);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL wr_in_scan cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      if (c < 5) exp_q.push_back(scan_exp(c, 0));
      else if (c == 5) exp_q.push_back(EXP_DONE);
      else exp_q.push_back(scan_exp(c - 5, 0));
    end
    for (int c = 0; c < 12; c++) begin
      step(4'h0, c <= 5, 10'd0);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL back_to_back cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid_shift();
    for (int c = 0; c < 6; c++) exp_q.push_back(scan_exp(c, 5));
    for (int c = 0; c < 6; c++) begin
      step(4'h0, c == 0, 10'd5);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL rst_pre cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
    // third SHIFT cycle: reset must take effect without a clock edge
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== EXP_HOLD) $display("FAIL rst_async: got %h want %h", obs, EXP_HOLD);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(EXP_HOLD);
    exp_q.push_back(EXP_HOLD);
    exp_q.push_back(EXP_FUNC);
    exp_q.push_back(EXP_FUNC);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) step(4'h0, 1'b0, '0);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL rst_post cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
    end
  endtask

`ifdef TRI_LCB_SEQ_ABORT_EN
  task automatic test_abort();
    logic [9:0] e;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) e = EXP_FUNC;
      else if (c <= 2) e = EXP_HOLD;
      else if (c <= 4) e = EXP_SHIFT;
      else if (c <= 6) e = EXP_HOLD;
      else if (c == 7) e = EXP_DONE;
      else if (c == 8) e = EXP_FUNC;
      else e = EXP_HOLD;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 11; c++) begin
      abort_drv = (c == 4);
      step(4'h0, (c == 0) || (c == 8), 10'd5);
      expv = exp_q.pop_front();
      n_checks++;
      if (obs !== expv) $display("FAIL abort cyc %0d: got %h want %h", c, obs, expv);
      else n_pass++;
      if (c == 7 || c == 9) begin
        n_checks++;
        if (bus.scan_aborted !== (c == 7))
          $display("FAIL scan_aborted cyc %0d: got %b want %b", c, bus.scan_aborted, c == 7);
        else n_pass++;
      end
    end
    abort_drv = 1'b0;
    // let the second session finish
    repeat (20) step(4'h0, 1'b0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_act_idle();
    test_scan_len(5, "scan_len5");
    test_scan_len(0, "scan_len0");
    test_wr_during_scan();
    test_back_to_back();
    test_scan_len(1023, "scan_len_max");
    test_rst_mid_shift();
`ifdef TRI_LCB_SEQ_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
